// File: rtl/seg_display_arbiter_if.sv
// Request/grant bus between the display requesters and the arbiter.
interface seg_display_arbiter_if;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   grant;
    logic [1:0]   owner;
    logic         owner_valid;
    logic         switch_pulse;
    logic [31:0]  dis_num;

    // Requester side: drives requests and data, observes the arbitration result.
    modport master (
        output req, req_data,
        input  grant, owner, owner_valid, switch_pulse, dis_num
    );

    // Arbiter side.
    modport slave (
        input  req, req_data,
        output grant, owner, owner_valid, switch_pulse, dis_num
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one seven-segment display driver between four
// requesters, with a minimum dwell time per owner while others are waiting.
module seg_display_arbiter #(
    parameter int unsigned DWELL_CYCLES = 100_000_000,
    parameter logic [31:0] IDLE_VALUE   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_display_arbiter_if.slave  bus
);
    localparam int unsigned N_REQ  = 4;
    localparam int unsigned CNT_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [1:0]         owner_q, owner_d;
    logic               valid_q, valid_d;
    logic               pulse_q, pulse_d;
    logic [31:0]        dis_q, dis_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         last_q, last_d;

    logic [N_REQ-1:0]   own_oh;
    logic [N_REQ-1:0]   others;
    logic [N_REQ-1:0]   cand;
    logic [1:0]         idx;
    logic [1:0]         win;
    logic               found;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= 2'd0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            dis_q   <= IDLE_VALUE;
            cnt_q   <= '0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
            dis_q   <= dis_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state: pick the candidate set, run round-robin, update dwell counter.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        valid_d = valid_q;
        pulse_d = 1'b0;
        cnt_d   = cnt_q;
        last_d  = last_q;
        cand    = '0;
        idx     = 2'd0;
        win     = 2'd0;
        found   = 1'b0;
        own_oh  = N_REQ'(1) << owner_q;
        others  = bus.req & ~own_oh;

        // Display data follows the registered owner one edge later.
        dis_d = valid_q ? bus.req_data[{owner_q, 5'b0} +: 32] : IDLE_VALUE;

        case (state_q)
            IDLE: cand = bus.req;
            HOLD: begin
                // Release wins over preempt; both pick among the other requesters.
                if (!bus.req[owner_q]) begin
                    cand = others;
                end else if (cnt_q == CNT_MAX) begin
                    cand = others;
                end
            end
            default: cand = '0;
        endcase

        for (int k = 0; k < N_REQ; k++) begin
            idx = last_q + 2'(k + 1);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end

        if (found) begin
            state_d = HOLD;
            grant_d = N_REQ'(1) << win;
            owner_d = win;
            valid_d = 1'b1;
            pulse_d = 1'b1;
            cnt_d   = '0;
            last_d  = win;
        end else if (state_q == HOLD) begin
            if (!bus.req[owner_q]) begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                cnt_d   = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign bus.grant        = grant_q;
    assign bus.owner        = owner_q;
    assign bus.owner_valid  = valid_q;
    assign bus.switch_pulse = pulse_q;
    assign bus.dis_num      = dis_q;

endmodule
